arrow_key_encoder: RTL

- Producer side of the arrow-key interface into the 6x6 cursor block.
- Converts four raw, bouncing, active-low pushbuttons into clean one-hot 4-bit move commands on `keys`.
- Each command is exactly one clock pulse, with optional hold-to-repeat.
- Sits between the board pushbuttons and the cursor/grid logic in the VGA project.

---
 rtl/arrow_pkg.sv | 34 +++
 rtl/sync_2ff.sv | 25 ++
 rtl/arrow_key_encoder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/arrow_pkg.sv
// Shared constants and types for the arrow-key interface.
// The cursor block imports the same key bit map.
package arrow_pkg;

    // Encoder FSM states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        HOLD     = 3'd2,
        REPEAT   = 3'd3,
        RELEASE  = 3'd4
    } state_t;

    // Bit positions in btn_n / keys
    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;

    localparam logic [3:0] KEYS_NONE = 4'b0000;

    // True when exactly one bit of a 4-bit vector is set
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    // Largest of three integers, used to size the shared counter
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// Resets to all zeros.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two register stages; the first may go metastable, the second settles it
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/arrow_key_encoder.sv
// Arrow-key encoder: debounces four active-low pushbuttons and emits
// single-cycle one-hot move pulses on keys, with optional hold-to-repeat.
//
// keys is a pulse-only output: there is no handshake. A non-zero value
// lasts exactly one clock and the consumer must act on it in that cycle.
module arrow_key_encoder
    import arrow_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 7500000,
    parameter int REPEAT_EN       = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] btn_n,
    output logic [3:0] keys,
    output logic       busy
);

    localparam int CNT_MAXV = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam int CW       = $clog2(CNT_MAXV + 1);

    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_SAT  = '1;

    // Active-high pressed vector after synchronization
    logic [3:0] s;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx, cnt_inc;
    logic [3:0]    vec, vec_nx;
    logic [3:0]    keys_nx;

    sync_2ff #(.WIDTH(4)) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (~btn_n),
        .q       (s)
    );

    // Saturating increment so the counter can never wrap, even when
    // HOLD waits indefinitely with auto-repeat disabled
    always_comb begin
        cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CNT_ONE;
    end

    // Next-state, counter and pulse decode
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        vec_nx   = vec;
        keys_nx  = KEYS_NONE;
        case (state)
            IDLE: begin
                if (s != 4'b0000) begin
                    if (is_onehot4(s)) begin
                        vec_nx   = s;
                        cnt_nx   = CNT_ONE;
                        state_nx = DEBOUNCE;
                    end else begin
                        // Chords are rejected; wait for a clean release
                        cnt_nx   = '0;
                        state_nx = RELEASE;
                    end
                end
            end
            DEBOUNCE: begin
                if (s != vec) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else if (cnt == DB_LAST) begin
                    keys_nx  = vec;
                    cnt_nx   = '0;
                    state_nx = HOLD;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            HOLD: begin
                if (s != vec) begin
                    cnt_nx   = '0;
                    state_nx = RELEASE;
                end else if ((REPEAT_EN != 0) && (cnt == RD_LAST)) begin
                    keys_nx  = vec;
                    cnt_nx   = '0;
                    state_nx = REPEAT;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            REPEAT: begin
                if (s != vec) begin
                    cnt_nx   = '0;
                    state_nx = RELEASE;
                end else if (cnt == RP_LAST) begin
                    keys_nx = vec;
                    cnt_nx  = '0;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            RELEASE: begin
                if (s != 4'b0000) begin
                    cnt_nx = '0;
                end else if (cnt == DB_LAST) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            default: begin
                cnt_nx   = '0;
                state_nx = RELEASE;
            end
        endcase
    end

    // State, counter and registered outputs; reset parks in RELEASE so a
    // button held through reset must be released before it can act
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= RELEASE;
            cnt   <= '0;
            vec   <= KEYS_NONE;
            keys  <= KEYS_NONE;
            busy  <= 1'b1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            vec   <= vec_nx;
            keys  <= keys_nx;
            busy  <= (state_nx != IDLE);
        end
    end

endmodule
